// File: rtl/request_issuer.sv
// Requester-side read issuer: formats request packets into the request NoC and
// tracks outstanding reads until a matching response or a timeout retires them.
module request_issuer #(
    parameter int DATA_W  = 16,
    parameter int RESP_W  = DATA_W + 9,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        id,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_reg_id,
    input  logic [1:0]        req_dest,
    input  logic              full,
    input  logic              almost_full,
    output logic [11:0]       dataOut,
    output logic              write,
    input  logic [RESP_W-1:0] resp_in,
    output logic              rd_valid,
    output logic [5:0]        rd_reg_id,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_timeout,
    output logic [3:0]        outstanding,
    output logic              err_unexpected
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       MAX_OUT_C = 4'(MAX_OUT);

    logic [11:0]        pend;
    logic               pend_v;
    logic [MAX_OUT-1:0] ent_v;
    logic [5:0]         ent_id  [MAX_OUT];
    logic [CNT_W-1:0]   ent_cnt [MAX_OUT];

    logic               send;
    logic               accept;
    logic               dup;
    logic [3:0]         live_cnt;
    logic [MAX_OUT-1:0] free_sel;
    logic [MAX_OUT-1:0] hit_sel;
    logic [MAX_OUT-1:0] exp_sel;
    logic               free_any;
    logic               hit;
    logic               exp_any;
    logic [5:0]         exp_id;

    logic               resp_v;
    logic [1:0]         resp_dest;
    logic [5:0]         resp_reg;
    logic [DATA_W-1:0]  resp_data;

    assign resp_v    = resp_in[0];
    assign resp_dest = resp_in[2:1];
    assign resp_reg  = resp_in[8:3];
    assign resp_data = resp_in[RESP_W-1:9];

    // A write issued last cycle is not yet visible in the FIFO flags, so it needs almost_full clear.
    assign send      = pend_v & (write ? ~almost_full : ~full);
    assign req_ready = (~pend_v | send) & (live_cnt < MAX_OUT_C) & ~dup;
    assign accept    = req_valid & req_ready;
    assign outstanding = live_cnt;

    always_comb begin
        live_cnt = '0;
        dup      = 1'b0;
        free_sel = '0;
        free_any = 1'b0;
        hit_sel  = '0;
        hit      = 1'b0;
        exp_sel  = '0;
        exp_any  = 1'b0;
        exp_id   = '0;
        for (int unsigned i = 0; i < MAX_OUT; i++) begin
            live_cnt = live_cnt + 4'(ent_v[i]);
            if (ent_v[i] && ent_id[i] == req_reg_id) dup = 1'b1;
            if (!ent_v[i] && !free_any) begin
                free_sel[i] = 1'b1;
                free_any    = 1'b1;
            end
            if (resp_v && resp_dest == id && ent_v[i] && ent_id[i] == resp_reg && !hit) begin
                hit_sel[i] = 1'b1;
                hit        = 1'b1;
            end
            if (ent_v[i] && ent_cnt[i] == CNT_MAX && !hit_sel[i] && !exp_any) begin
                exp_sel[i] = 1'b1;
                exp_any    = 1'b1;
                exp_id     = ent_id[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend           <= '0;
            pend_v         <= 1'b0;
            dataOut        <= '0;
            write          <= 1'b0;
            rd_valid       <= 1'b0;
            rd_reg_id      <= '0;
            rd_data        <= '0;
            rd_timeout     <= 1'b0;
            err_unexpected <= 1'b0;
            ent_v          <= '0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                ent_id[i]  <= '0;
                ent_cnt[i] <= '0;
            end
        end else begin
            write <= send;
            if (send) begin
                dataOut <= pend;
                pend_v  <= 1'b0;
            end
            if (accept) begin
                pend   <= {1'b0, req_reg_id, id, req_dest, 1'b1};
                pend_v <= 1'b1;
            end

            // Completion wins the report slot; an expired entry waits with a saturated count.
            rd_valid <= hit | exp_any;
            if (hit) begin
                rd_reg_id  <= resp_reg;
                rd_data    <= resp_data;
                rd_timeout <= 1'b0;
            end else if (exp_any) begin
                rd_reg_id  <= exp_id;
                rd_data    <= '0;
                rd_timeout <= 1'b1;
            end
            if (resp_v && !hit) err_unexpected <= 1'b1;

            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                if (ent_v[i] && ent_cnt[i] != CNT_MAX) ent_cnt[i] <= ent_cnt[i] + 1'b1;
                if (hit_sel[i] || (exp_sel[i] && !hit)) ent_v[i] <= 1'b0;
                if (accept && free_sel[i]) begin
                    ent_v[i]   <= 1'b1;
                    ent_id[i]  <= req_reg_id;
                    ent_cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_request_issuer.sv
// Self-checking bench for request_issuer: directed scenarios plus a randomized
// run compared against a timestamp-based reference model.
module tb_request_issuer;

    localparam int DW = 16;
    localparam int RW = DW + 9;
    localparam int MO = 4;
    localparam int TO = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [1:0]    id;
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_reg_id;
    logic [1:0]    req_dest;
    logic          full;
    logic          almost_full;
    logic [11:0]   dataOut;
    logic          write;
    logic [RW-1:0] resp_in;
    logic          rd_valid;
    logic [5:0]    rd_reg_id;
    logic [DW-1:0] rd_data;
    logic          rd_timeout;
    logic [3:0]    outstanding;
    logic          err_unexpected;

    int checks = 0;
    int failures = 0;

    request_issuer #(
        .DATA_W (DW),
        .RESP_W (RW),
        .MAX_OUT(MO),
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id            (id),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_reg_id    (req_reg_id),
        .req_dest      (req_dest),
        .full          (full),
        .almost_full   (almost_full),
        .dataOut       (dataOut),
        .write         (write),
        .resp_in       (resp_in),
        .rd_valid      (rd_valid),
        .rd_reg_id     (rd_reg_id),
        .rd_data       (rd_data),
        .rd_timeout    (rd_timeout),
        .outstanding   (outstanding),
        .err_unexpected(err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Reference model state: each slot remembers the cycle its age started at.
    typedef struct {
        bit       live;
        bit [5:0] rid;
        int       born;
    } slot_t;

    slot_t       m_slot [MO];
    bit          m_pend_v;
    bit [11:0]   m_pend;
    bit          m_write;
    bit [11:0]   m_dout;
    bit          m_rdv;
    bit [5:0]    m_rdid;
    bit [DW-1:0] m_rdd;
    bit          m_rdto;
    bit          m_err;
    int          tcyc;

    function automatic logic [11:0] pkt(input logic [5:0] r, input logic [1:0] s, input logic [1:0] d);
        return 12'(1 + 2 * int'(d) + 8 * int'(s) + 32 * int'(r));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_reg_id  = '0;
        req_dest    = '0;
        full        = 1'b0;
        almost_full = 1'b0;
        resp_in     = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [41:0] all_out;
        idle_inputs();
        id    = 2'd0;
        reset = 1'b1;
        tick();
        @(negedge clk);
        all_out = {dataOut, write, rd_valid, rd_reg_id, rd_data, rd_timeout, outstanding, err_unexpected};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || outstanding !== 4'd0 || write !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready=%b outstanding=%0d write=%b exp 1/0/0", req_ready, outstanding, write);
        end
    endtask

    task automatic test_single();
        apply_reset();
        id         = 2'd1;
        req_valid  = 1'b1;
        req_reg_id = 6'd5;
        req_dest   = 2'd2;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req_ready); end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (write !== 1'b0 || outstanding !== 4'd1) begin
            failures++;
            $display("FAIL single_cycle1 write=%b outstanding=%0d exp 0/1", write, outstanding);
        end
        tick();
        @(negedge clk);
        checks++;
        if (write !== 1'b1 || dataOut !== 12'h0AD) begin
            failures++;
            $display("FAIL single_packet write=%b dataOut=%h exp 1/0ad", write, dataOut);
        end
        tick();
        @(negedge clk);
        checks++;
        if (write !== 1'b0) begin failures++; $display("FAIL single_write_pulse got=%b exp=0", write); end
        resp_in = {16'hBEEF, 6'd5, 2'd1, 1'b1};
        tick();
        resp_in = '0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || rd_reg_id !== 6'd5 || rd_timeout !== 1'b0
            || outstanding !== 4'd0 || err_unexpected !== 1'b0) begin
            failures++;
            $display("FAIL resp_complete v=%b data=%h reg=%0d to=%b out=%0d err=%b exp 1/beef/5/0/0/0",
                     rd_valid, rd_data, rd_reg_id, rd_timeout, outstanding, err_unexpected);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL resp_pulse got=%b exp=0", rd_valid); end
        resp_in = {16'hBEEF, 6'd5, 2'd3, 1'b1};
        tick();
        resp_in = '0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || err_unexpected !== 1'b1) begin
            failures++;
            $display("FAIL resp_wrong_dest rd_valid=%b err=%b exp 0/1", rd_valid, err_unexpected);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_w;
        bit exp_v;
        apply_reset();
        id = 2'd1;
        for (int k = 0; k < 14; k++) begin
            req_valid  = (k < 5);
            req_reg_id = 6'(k + 1);
            req_dest   = 2'(k);
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, req_ready); end
            end
            if (k == 4) begin
                checks++;
                if (req_ready !== 1'b0 || outstanding !== 4'd4) begin
                    failures++;
                    $display("FAIL b2b_full_table ready=%b outstanding=%0d exp 0/4", req_ready, outstanding);
                end
            end
            exp_w = (k >= 2 && k <= 5);
            checks++;
            if (write !== exp_w || (exp_w && dataOut !== pkt(6'(k - 1), 2'd1, 2'(k - 2)))) begin
                failures++;
                $display("FAIL b2b_write k=%0d write=%b dataOut=%h exp %b/%h", k, write, dataOut, exp_w,
                         pkt(6'(k - 1), 2'd1, 2'(k - 2)));
            end
            exp_v = (k >= 9 && k <= 12);
            checks++;
            if (rd_valid !== exp_v || (exp_v && (rd_timeout !== 1'b1 || rd_data !== '0 || rd_reg_id !== 6'(k - 8)))) begin
                failures++;
                $display("FAIL timeout_report k=%0d v=%b to=%b data=%h reg=%0d exp v=%b to=1 data=0 reg=%0d",
                         k, rd_valid, rd_timeout, rd_data, rd_reg_id, exp_v, k - 8);
            end
            if (k == 13) begin
                checks++;
                if (err_unexpected !== 1'b0 || outstanding !== 4'd0) begin
                    failures++;
                    $display("FAIL timeout_drain err=%b outstanding=%0d exp 0/0", err_unexpected, outstanding);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        resp_in   = {16'h5555, 6'd1, 2'd1, 1'b1};
        tick();
        resp_in = '0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || err_unexpected !== 1'b1) begin
            failures++;
            $display("FAIL late_response rd_valid=%b err=%b exp 0/1", rd_valid, err_unexpected);
        end
    endtask

    task automatic test_flow_control();
        int nxt;
        bit exp_w;
        apply_reset();
        id         = 2'd1;
        full       = 1'b1;
        req_valid  = 1'b1;
        req_reg_id = 6'd9;
        req_dest   = 2'd0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL full_first_ready got=%b exp=1", req_ready); end
        tick();
        req_reg_id = 6'd10;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || write !== 1'b0) begin
                failures++;
                $display("FAIL full_hold k=%0d ready=%b write=%b exp 0/0", k, req_ready, write);
            end
            tick();
        end
        full      = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (write !== 1'b0) begin failures++; $display("FAIL full_drop_cycle write=%b exp=0", write); end
        tick();
        @(negedge clk);
        checks++;
        if (write !== 1'b1 || dataOut !== pkt(6'd9, 2'd1, 2'd0)) begin
            failures++;
            $display("FAIL full_release write=%b dataOut=%h exp 1/%h", write, dataOut, pkt(6'd9, 2'd1, 2'd0));
        end

        apply_reset();
        almost_full = 1'b1;
        nxt = 1;
        for (int k = 0; k <= 8; k++) begin
            req_valid  = (nxt <= 4);
            req_reg_id = 6'(nxt);
            req_dest   = 2'd0;
            @(negedge clk);
            if (k <= 6) begin
                checks++;
                if (req_ready !== (k < 2 || (k % 2) == 1)) begin
                    failures++;
                    $display("FAIL af_ready k=%0d got=%b exp=%b", k, req_ready, (k < 2 || (k % 2) == 1));
                end
            end
            exp_w = (k >= 2 && (k % 2) == 0);
            checks++;
            if (write !== exp_w || (exp_w && dataOut !== pkt(6'(k / 2), 2'd1, 2'd0))) begin
                failures++;
                $display("FAIL af_write k=%0d write=%b dataOut=%h exp %b/%h", k, write, dataOut, exp_w,
                         pkt(6'(k / 2), 2'd1, 2'd0));
            end
            if (k == 8) begin
                checks++;
                if (outstanding !== 4'd4) begin failures++; $display("FAIL af_outstanding got=%0d exp=4", outstanding); end
            end
            if (req_valid && req_ready) nxt++;
            tick();
        end
    endtask

    task automatic test_duplicate();
        apply_reset();
        id         = 2'd2;
        req_valid  = 1'b1;
        req_reg_id = 6'd7;
        req_dest   = 2'd1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL dup_first_ready got=%b exp=1", req_ready); end
        tick();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) resp_in = {16'h1234, 6'd7, 2'd2, 1'b1};
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin failures++; $display("FAIL dup_blocked k=%0d got=%b exp=0", k, req_ready); end
            tick();
        end
        resp_in   = '0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 16'h1234 || rd_reg_id !== 6'd7) begin
            failures++;
            $display("FAIL dup_reuse ready=%b v=%b data=%h reg=%0d exp 1/1/1234/7", req_ready, rd_valid, rd_data, rd_reg_id);
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        id         = 2'd1;
        req_valid  = 1'b1;
        req_reg_id = 6'd3;
        resp_in    = {16'h0000, 6'd60, 2'd1, 1'b1};
        tick();
        req_reg_id = 6'd4;
        resp_in    = '0;
        @(negedge clk);
        checks++;
        if (err_unexpected !== 1'b1) begin failures++; $display("FAIL midreset_err_set got=%b exp=1", err_unexpected); end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (write !== 1'b1 || outstanding !== 4'd2) begin
            failures++;
            $display("FAIL midreset_pre write=%b outstanding=%0d exp 1/2", write, outstanding);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (write !== 1'b0 || dataOut !== '0 || outstanding !== 4'd0 || err_unexpected !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear write=%b dataOut=%h out=%0d err=%b v=%b exp all 0",
                     write, dataOut, outstanding, err_unexpected, rd_valid);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0 || write !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet k=%0d rd_valid=%b write=%b exp 0/0", k, rd_valid, write);
            end
            tick();
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < MO; s++) m_slot[s] = '{live: 1'b0, rid: 6'd0, born: 0};
        m_pend_v = 0; m_pend = '0; m_write = 0; m_dout = '0;
        m_rdv = 0; m_rdid = '0; m_rdd = '0; m_rdto = 0; m_err = 0;
        tcyc = 0;
    endtask

    task automatic test_random();
        int          n;
        int          done;
        int          tos;
        int          fr;
        int          s;
        bit          dupl;
        bit          snd;
        bit          acc;
        bit          exp_ready;
        logic [5:0]  r;
        logic [1:0]  d;
        logic [RW-1:0] tmp;
        apply_reset();
        id = 2'($urandom_range(0, 3));
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid   = ($urandom_range(0, 99) < 60);
            req_reg_id  = 6'($urandom_range(0, 7));
            req_dest    = 2'($urandom);
            full        = ($urandom_range(0, 99) < 25);
            almost_full = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 35) begin
                s = $urandom_range(0, MO - 1);
                r = (m_slot[s].live && $urandom_range(0, 9) < 8) ? m_slot[s].rid : 6'($urandom_range(0, 7));
                d = ($urandom_range(0, 9) < 8) ? id : 2'($urandom);
                resp_in = {16'($urandom), r, d, 1'b1};
            end else begin
                tmp = RW'($urandom);
                tmp[0] = 1'b0;
                resp_in = tmp;
            end
            @(negedge clk);

            n = 0;
            dupl = 0;
            for (int i = 0; i < MO; i++) begin
                if (m_slot[i].live) begin
                    n++;
                    if (m_slot[i].rid == req_reg_id) dupl = 1;
                end
            end
            snd = m_pend_v && (m_write ? !almost_full : !full);
            exp_ready = (!m_pend_v || snd) && n < MO && !dupl;

            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
            end
            checks++;
            if (write !== m_write || dataOut !== m_dout) begin
                failures++;
                $display("FAIL rnd_packet cyc=%0d write=%b dataOut=%h exp %b/%h", cyc, write, dataOut, m_write, m_dout);
            end
            checks++;
            if (rd_valid !== m_rdv || (m_rdv && (rd_reg_id !== m_rdid || rd_data !== m_rdd || rd_timeout !== m_rdto))) begin
                failures++;
                $display("FAIL rnd_readback cyc=%0d v=%b reg=%0d data=%h to=%b exp %b/%0d/%h/%b",
                         cyc, rd_valid, rd_reg_id, rd_data, rd_timeout, m_rdv, m_rdid, m_rdd, m_rdto);
            end
            checks++;
            if (outstanding !== 4'(n) || err_unexpected !== m_err) begin
                failures++;
                $display("FAIL rnd_status cyc=%0d outstanding=%0d err=%b exp %0d/%b", cyc, outstanding, err_unexpected, n, m_err);
            end

            acc  = req_valid && exp_ready;
            done = -1;
            if (resp_in[0] && resp_in[2:1] == id)
                for (int i = 0; i < MO; i++)
                    if (m_slot[i].live && m_slot[i].rid == resp_in[8:3]) done = i;
            if (resp_in[0] && done < 0) m_err = 1;
            tos = -1;
            if (done < 0)
                for (int i = MO - 1; i >= 0; i--)
                    if (m_slot[i].live && (tcyc - m_slot[i].born) >= TO - 1) tos = i;
            fr = -1;
            for (int i = MO - 1; i >= 0; i--) if (!m_slot[i].live) fr = i;
            m_rdv = 0;
            if (done >= 0) begin
                m_slot[done].live = 0;
                m_rdv  = 1;
                m_rdid = resp_in[8:3];
                m_rdd  = resp_in[RW-1:9];
                m_rdto = 0;
            end else if (tos >= 0) begin
                m_slot[tos].live = 0;
                m_rdv  = 1;
                m_rdid = m_slot[tos].rid;
                m_rdd  = '0;
                m_rdto = 1;
            end
            if (acc) m_slot[fr] = '{live: 1'b1, rid: req_reg_id, born: tcyc + 1};
            if (snd) begin
                m_dout   = m_pend;
                m_pend_v = 0;
            end
            m_write = snd;
            if (acc) begin
                m_pend   = pkt(req_reg_id, id, req_dest);
                m_pend_v = 1;
            end
            tcyc++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        id    = 2'd0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_duplicate();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
